audio_dac_tx: RTL

AUDIO_DAC_TX -- requirements
Module: audio_dac_tx

---
 rtl/audio_dac_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/audio_dac_tx.sv
// rtl/audio_dac_tx.sv - I2S stereo DAC transmitter fed by a stereo-pair FIFO.
// Optional macro AUDIO_DAC_TX_UNDERRUN_CNT_EN adds a saturating underrun_count output.
module audio_dac_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [DATA_WIDTH-1:0] sample_left,
  input  logic [DATA_WIDTH-1:0] sample_right,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  input  logic                  audio_external_BCLK,
  input  logic                  audio_external_DACLRCK,
  output logic                  audio_external_DACDAT,
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
  output logic [15:0]           underrun_count,
`endif
  output logic                  underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  logic [1:0] bclk_sync_q;
  logic [1:0] lrck_sync_q;
  logic       bclk_dly_q;
  logic       lrck_dly_q;
  logic       bclk_fall;
  logic       lrck_fall;
  logic       lrck_rise;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      bclk_dly_q  <= 1'b0;
      lrck_dly_q  <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], audio_external_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], audio_external_DACLRCK};
      bclk_dly_q  <= bclk_sync_q[1];
      lrck_dly_q  <= lrck_sync_q[1];
    end
  end

  assign bclk_fall = bclk_dly_q & ~bclk_sync_q[1];
  assign lrck_fall = lrck_dly_q & ~lrck_sync_q[1];
  assign lrck_rise = ~lrck_dly_q & lrck_sync_q[1];

  // Entries are packed {left, right}; extra pointer bit separates full from empty.
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    pop;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign sample_ready = ~fifo_full;
  assign push         = sample_valid & ~fifo_full;
  assign pop          = lrck_fall & ~fifo_empty;
  assign rd_data      = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {sample_left, sample_right};
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  state_t                state_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [CW-1:0]         cnt_q;
  logic                  dacdat_q;
  logic                  underrun_q;
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
  logic [15:0]           ucount_q;
`endif

  // LRCK edges take priority over a coincident BCLK strobe, which delays the MSB by one BCLK.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q    <= ST_SYNC;
      shift_q    <= '0;
      hold_q     <= '0;
      cnt_q      <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
      ucount_q   <= '0;
`endif
    end else begin
      underrun_q <= 1'b0;
      if (lrck_fall) begin
        state_q <= ST_LEFT;
        cnt_q   <= CW'(DATA_WIDTH);
        if (fifo_empty) begin
          shift_q    <= '0;
          hold_q     <= '0;
          underrun_q <= 1'b1;
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
          if (ucount_q != 16'hFFFF) ucount_q <= ucount_q + 16'd1;
`endif
        end else begin
          shift_q <= rd_data[2*DATA_WIDTH-1:DATA_WIDTH];
          hold_q  <= rd_data[DATA_WIDTH-1:0];
        end
      end else if (lrck_rise && state_q != ST_SYNC) begin
        state_q <= ST_RIGHT;
        shift_q <= hold_q;
        cnt_q   <= CW'(DATA_WIDTH);
      end else if (bclk_fall) begin
        if (cnt_q != '0) begin
          dacdat_q <= shift_q[DATA_WIDTH-1];
          shift_q  <= {shift_q[DATA_WIDTH-2:0], 1'b0};
          cnt_q    <= cnt_q - CW'(1);
        end else begin
          dacdat_q <= 1'b0;
        end
      end
    end
  end

  assign audio_external_DACDAT = dacdat_q;
  assign underrun              = underrun_q;
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
  assign underrun_count        = ucount_q;
`endif

endmodule
